// File: rtl/trivium_word_cipher_if.sv
// Valid/ready word stream carrying plaintext into, or ciphertext out of, the
// keystream XOR block.
//   valid : producer has a word on data
//   ready : consumer takes the word this cycle
//   data  : WIDTH-bit word
// master modport = producer side, slave modport = consumer side.
interface trivium_word_cipher_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/trivium_word_cipher.sv
// Keystream word cipher: requests keystream bits one per cycle from a Trivium
// generator, packs them LSB-first into a WIDTH-bit keystream word, and XORs
// that word with each accepted plaintext word. One keystream word per data word.
//
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   ks_ready    : generator initialised
//   ks_en       : combinational bit request to the generator
//   ks_bit      : keystream bit, valid the cycle after ks_en
//   in_stream   : plaintext word stream (slave); in_stream.ready is combinational
//   out_stream  : registered ciphertext word stream (master)
//   bypass      : only with TRIVIUM_CIPHER_BYPASS_EN defined; passes the word
//                 through unencrypted without consuming keystream
//
// Optional feature macro: TRIVIUM_CIPHER_BYPASS_EN
module trivium_word_cipher #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ks_ready,
  output logic                  ks_en,
  input  logic                  ks_bit,
`ifdef TRIVIUM_CIPHER_BYPASS_EN
  input  logic                  bypass,
`endif
  trivium_word_cipher_if.slave  in_stream,
  trivium_word_cipher_if.master out_stream
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] ks_word,   ks_word_n;
  logic [CW-1:0]    req_cnt,   req_cnt_n;
  logic [CW-1:0]    rcv_cnt,   rcv_cnt_n;
  logic             pend,      pend_n;
  logic             ks_full,   ks_full_n;
  logic             out_valid, out_valid_n;
  logic [WIDTH-1:0] out_data,  out_data_n;

  logic             out_free;
  logic             in_ready;
  logic             fire;
  logic             plain;

  // Handshake and bit-request decode; rst gating keeps both low in reset.
  always_comb begin
    out_free = !out_valid || out_stream.ready;
`ifdef TRIVIUM_CIPHER_BYPASS_EN
    plain    = bypass;
`else
    plain    = 1'b0;
`endif
    in_ready = rst && out_free && (ks_full || plain);
    fire     = in_stream.valid && in_ready;
    ks_en    = rst && ks_ready && !ks_full && (req_cnt < CW'(WIDTH));
  end

  assign in_stream.ready  = in_ready;
  assign out_stream.valid = out_valid;
  assign out_stream.data  = out_data;

  // Next-state: keystream fill, word consumption, output register.
  always_comb begin
    ks_word_n   = ks_word;
    req_cnt_n   = req_cnt;
    rcv_cnt_n   = rcv_cnt;
    pend_n      = ks_en;
    ks_full_n   = ks_full;
    out_valid_n = out_valid;
    out_data_n  = out_data;

    if (ks_en) begin
      req_cnt_n = req_cnt + CW'(1);
    end

    // Bit requested last cycle arrives now, even if ks_ready has since dropped.
    if (pend) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (rcv_cnt == CW'(i)) begin
          ks_word_n[i] = ks_bit;
        end
      end
      rcv_cnt_n = rcv_cnt + CW'(1);
      if (rcv_cnt == CW'(WIDTH - 1)) begin
        ks_full_n = 1'b1;
      end
    end

    if (out_valid && out_stream.ready) begin
      out_valid_n = 1'b0;
    end

    if (fire) begin
      out_valid_n = 1'b1;
      if (plain) begin
        out_data_n = in_stream.data;
      end else begin
        out_data_n = in_stream.data ^ ks_word;
        ks_full_n  = 1'b0;
        req_cnt_n  = '0;
        rcv_cnt_n  = '0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ks_word   <= '0;
      req_cnt   <= '0;
      rcv_cnt   <= '0;
      pend      <= 1'b0;
      ks_full   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      ks_word   <= ks_word_n;
      req_cnt   <= req_cnt_n;
      rcv_cnt   <= rcv_cnt_n;
      pend      <= pend_n;
      ks_full   <= ks_full_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

endmodule

// File: tb/tb_trivium_word_cipher.sv
// Bench for trivium_word_cipher: stub keystream generator fed from a bit
// array, directed scenarios, then randomized traffic scored against a
// word-level model (word k since reset uses stream bits k*WIDTH.. LSB-first).
module tb_trivium_word_cipher;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NBITS = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ks_ready = 1'b0;
  logic ks_en;
  logic ks_bit;
`ifdef TRIVIUM_CIPHER_BYPASS_EN
  logic bypass = 1'b0;
`endif

  trivium_word_cipher_if #(.WIDTH(WIDTH)) in_stream ();
  trivium_word_cipher_if #(.WIDTH(WIDTH)) out_stream ();

  trivium_word_cipher #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ks_ready   (ks_ready),
    .ks_en      (ks_en),
    .ks_bit     (ks_bit),
`ifdef TRIVIUM_CIPHER_BYPASS_EN
    .bypass     (bypass),
`endif
    .in_stream  (in_stream),
    .out_stream (out_stream)
  );

  always #5 clk = ~clk;

  // Stub generator: one bit per request, delivered the following cycle.
  logic        stream [NBITS];
  int unsigned gen_ptr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      gen_ptr <= 0;
      ks_bit  <= 1'b0;
    end else if (ks_en) begin
      ks_bit  <= stream[gen_ptr % NBITS];
      gen_ptr <= gen_ptr + 1;
    end
  end

  // Reference model state.
  int unsigned      words_used;
  logic [WIDTH-1:0] exp_q [$];
  logic             last_fire;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  function automatic logic [WIDTH-1:0] ks_word_of(int unsigned k);
    logic [WIDTH-1:0] w;
    for (int b = 0; b < WIDTH; b++) w[b] = stream[(k * WIDTH + b) % NBITS];
    return w;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_plain();
`ifdef TRIVIUM_CIPHER_BYPASS_EN
    return bypass;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: called at a negedge with inputs already set; returns at next negedge.
  task automatic step();
    logic             fire, oacc, stall, plain;
    logic [WIDTH-1:0] od_before, in_d;
    #1;
    fire      = in_stream.valid && in_stream.ready;
    oacc      = out_stream.valid && out_stream.ready;
    stall     = out_stream.valid && !out_stream.ready;
    od_before = out_stream.data;
    in_d      = in_stream.data;
    plain     = is_plain();
    if (stall)     check("ready_in_stall", in_stream.ready, 0);
    if (!ks_ready) check("en_without_ks_ready", ks_en, 0);
    check("no_lookahead_request", gen_ptr <= (words_used + 1) * WIDTH, 1);
    if (oacc) begin
      if (exp_q.size() == 0) check("unexpected_out", 1, 0);
      else check("out_word", out_stream.data, exp_q.pop_front());
    end
    if (fire) begin
      if (plain) exp_q.push_back(in_d);
      else begin
        check("fire_before_fill", gen_ptr >= (words_used + 1) * WIDTH, 1);
        exp_q.push_back(in_d ^ ks_word_of(words_used));
        words_used++;
      end
    end
    last_fire = fire;
    @(negedge clk);
    if (stall) begin
      check("stall_hold_data", out_stream.data, od_before);
      check("stall_hold_valid", out_stream.valid, 1);
    end
  endtask

  task automatic wait_fire();
    last_fire = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (last_fire) break;
    end
    check("fire_timeout", last_fire, 1);
  endtask

  // Assert reset at a negedge, check reset outputs, release two cycles later.
  task automatic apply_reset();
    rst = 1'b0;
    in_stream.valid = 1'b0;
    #1;
    check("rst_ks_en", ks_en, 0);
    check("rst_in_ready", in_stream.ready, 0);
    check("rst_out_valid", out_stream.valid, 0);
    check("rst_out_data", out_stream.data, 0);
    repeat (2) @(negedge clk);
    words_used = 0;
    exp_q.delete();
    rst = 1'b1;
  endtask

  task automatic load_patterns();
    logic [15:0] pat;
    pat = 16'b1001_1010_0110_0101;  // bits 0..15 = 1,0,1,0,0,1,1,0, 0,1,0,1,1,0,0,1
    for (int i = 0; i < 16; i++) stream[i] = pat[i];
  endtask

  initial begin
    int unsigned      en_cnt, gap_en, first_ready;
    logic [11:0]      en_mask;
    logic [WIDTH-1:0] hold_data;

    for (int i = 0; i < NBITS; i++) stream[i] = 1'($urandom);
    load_patterns();
    in_stream.valid = 1'b0;
    in_stream.data  = '0;
    out_stream.ready = 1'b1;
    ks_ready = 1'b1;
    @(negedge clk);

    // Fill timing and first word.
    apply_reset();
    en_cnt = 0; first_ready = 99; en_mask = '0;
    for (int c = 0; c < 12; c++) begin
      #1;
      en_mask[c] = ks_en;
      if (ks_en) en_cnt++;
      if (in_stream.ready && first_ready == 99) first_ready = c;
      step();
    end
    check("fill_en_count", en_cnt, 8);
    check("fill_en_pattern", en_mask, 12'h0FF);
    check("fill_ready_cycle", first_ready, 9);
    in_stream.valid = 1'b1; in_stream.data = 8'h00;
    step();
    check("word0_valid", out_stream.valid, 1);
    check("word0_data", out_stream.data, 8'h65);

    // Downstream stall while the next keystream word fills.
    out_stream.ready = 1'b0;
    in_stream.data = 8'hFF;
    repeat (12) step();
    #1;
    check("stall_blocks_ready", in_stream.ready, 0);
    check("stall_data", out_stream.data, 8'h65);
    out_stream.ready = 1'b1;
    #1;
    check("release_ready", in_stream.ready, 1);
    step();
    in_stream.valid = 1'b0;
    check("word1_valid", out_stream.valid, 1);
    check("word1_data", out_stream.data, 8'h65);
    repeat (2) step();

    // ks_ready gap after the third request.
    apply_reset();
    en_cnt = 0;
    for (int i = 0; i < 20 && en_cnt < 3; i++) begin
      #1;
      if (ks_en) en_cnt++;
      step();
    end
    ks_ready = 1'b0;
    gap_en = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (ks_en) gap_en++;
      step();
    end
    check("gap_no_en", gap_en, 0);
    ks_ready = 1'b1;
    in_stream.valid = 1'b1; in_stream.data = 8'h00;
    wait_fire();
    in_stream.valid = 1'b0;
    check("gap_word_data", out_stream.data, 8'h65);
    repeat (2) step();

    // Reset mid-fill with an output pending.
    apply_reset();
    out_stream.ready = 1'b0;
    in_stream.valid = 1'b1; in_stream.data = 8'h00;
    wait_fire();
    in_stream.valid = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_stream.valid, 0);
    check("midrst_out_data", out_stream.data, 0);
    check("midrst_in_ready", in_stream.ready, 0);
    check("midrst_ks_en", ks_en, 0);
    @(negedge clk);
    out_stream.ready = 1'b1;
    apply_reset();
    in_stream.valid = 1'b1; in_stream.data = 8'h00;
    wait_fire();
    in_stream.valid = 1'b0;
    check("midrst_refill_data", out_stream.data, 8'h65);
    repeat (2) step();

`ifdef TRIVIUM_CIPHER_BYPASS_EN
    // Bypass word consumes no keystream.
    apply_reset();
    bypass = 1'b1;
    in_stream.valid = 1'b1; in_stream.data = 8'h3C;
    #1;
    check("byp_ready_unfilled", in_stream.ready, 1);
    step();
    check("byp_data", out_stream.data, 8'h3C);
    bypass = 1'b0;
    in_stream.data = 8'h00;
    wait_fire();
    in_stream.valid = 1'b0;
    check("byp_then_xor", out_stream.data, 8'h65);
    repeat (2) step();
`endif

    // Randomized traffic.
    for (int i = 0; i < NBITS; i++) stream[i] = 1'($urandom);
    apply_reset();
    hold_data = WIDTH'($urandom);
    last_fire = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ks_ready = ($urandom_range(0, 7) != 0);
      out_stream.ready = ($urandom_range(0, 3) != 0);
      if (last_fire || !in_stream.valid) begin
        hold_data = WIDTH'($urandom);
        in_stream.valid = 1'($urandom);
`ifdef TRIVIUM_CIPHER_BYPASS_EN
        bypass = ($urandom_range(0, 3) == 0);
`endif
      end
      in_stream.data = hold_data;
      step();
    end
    in_stream.valid = 1'b0;
    out_stream.ready = 1'b1;
    ks_ready = 1'b1;
    repeat (4) step();
    check("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trivium_word_cipher.md
Name: trivium_word_cipher

Overview:
- Downstream consumer of the Trivium keystream generator.
- Drives the generator's enable and collects keystream bits serially into WIDTH-bit keystream words.
- XORs each keystream word with a plaintext word accepted over a valid/ready handshake, and presents the result on a registered valid/ready output.
- Sits between the keystream generator and the byte/word datapath of the encrypt/decrypt pipeline; one keystream word is consumed per data word.

Parameters:
- WIDTH, 8, data/keystream word width in bits (legal: 2..32).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- ks_ready  input  1  generator initialised; keystream bits may be requested
- ks_en  output  1  request one keystream bit from generator this cycle
- ks_bit  input  1  keystream bit; valid exactly 1 cycle after a cycle with ks_en=1
- in_valid  input  1  plaintext word valid
- in_ready  output  1  block accepts plaintext word this cycle
- in_data  input  WIDTH  plaintext word
- out_valid  output  1  ciphertext word valid
- out_ready  input  1  downstream accepts ciphertext word
- out_data  output  WIDTH  ciphertext word

Behaviour:
- Reset (rst=0, async):
  - ks_en=0, in_ready=0, out_valid=0, out_data=0.
  - ks_word=0, req_cnt=0, rcv_cnt=0, pend=0, ks_full=0.
- Keystream fill:
  - ks_en = ks_ready && !ks_full && (req_cnt < WIDTH). Combinational.
  - Cycle with ks_en=1: req_cnt++, pend<=1. Otherwise pend<=0.
  - Cycle with pend=1: ks_word[rcv_cnt] <= ks_bit; rcv_cnt++.
  - Bit order: the first keystream bit lands in bit 0 (LSB-first).
  - ks_full <= 1 when the WIDTH-th bit is captured.
  - Fill latency: WIDTH+1 cycles from the first ks_en to ks_full=1 when ks_ready is held high.
- ks_ready dropping mid-fill:
  - Stop requesting immediately.
  - A bit already in flight (pend=1) is still captured.
  - Collected bits are retained; fill resumes when ks_ready returns, with no bit lost or duplicated.
- Input handshake:
  - in_ready = ks_full && (!out_valid || out_ready). Combinational.
  - Fire = in_valid && in_ready.
- On fire:
  - out_data <= in_data ^ ks_word; out_valid <= 1.
  - ks_full <= 0; req_cnt <= 0; rcv_cnt <= 0.
  - Refill begins the following cycle.
- Output:
  - out_valid clears on out_ready && out_valid unless a new fire occurs in the same cycle. A simultaneous fire reloads out_data and keeps out_valid=1.
  - out_data is held stable while out_valid && !out_ready.
- Throughput: at most one word per WIDTH+2 cycles (fill plus handshake).
- in_valid with ks_full=0: no acceptance; the input word waits and its keystream is never reused.
- Keystream words are used strictly in generation order; no keystream bit is ever dropped or reused.
- State summary (derived from ks_full/out_valid):
  - FILL: ks_full=0.
  - READY: ks_full=1, in_ready per the rule above.
  - STALL: ks_full=1, out_valid=1, out_ready=0.
- Reset mid-operation: all state cleared; partial keystream words are discarded. The generator is reset by the same rst.

Optional Feature:
- Macro TRIVIUM_CIPHER_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit).
  - With bypass=1: in_ready = !out_valid || out_ready, regardless of ks_full.
  - On fire: out_data <= in_data unmodified. ks_word, ks_full and the counters are untouched, so no keystream is consumed.
  - Fill continues in the background.
  - With bypass=0: behaviour is identical to the base block.
- When undefined: no bypass port; base behaviour only.

Test Plan:
- Reset then ks_ready=1, stub generator bits 1,0,1,0,0,1,1,0 (WIDTH=8):
  - ks_en high for exactly 8 cycles.
  - in_ready rises on cycle 9.
  - in_data=0x00 -> out_data=0x65, out_valid=1.
- Next word, stub bits 0,1,0,1,1,0,0,1 -> ks_word=0x9A; in_data=0xFF -> out_data=0x65.
- ks_ready dropped after the 3rd request for 5 cycles, same first pattern:
  - No ks_en during the gap.
  - in_data=0x00 -> out_data=0x65 (no bit lost or duplicated).
- out_ready=0 for 10 cycles after the first output:
  - out_data held at 0x65.
  - in_ready=0 even when ks_full=1.
  - Releasing out_ready with in_valid=1 makes the next word fire in the same cycle; out_valid stays 1.
- Assert rst=0 after 4 keystream bits captured:
  - Outputs clear immediately.
  - After release, ks_word refills from bit 0.
- TRIVIUM_CIPHER_BYPASS_EN defined, bypass=1, in_data=0x3C:
  - out_data=0x3C.
  - A following bypass=0 word still XORs with the first keystream word (0x65).
